noc_pkt_sink: RTL
=================

// Module: noc_pkt_sink
// PURPOSE
//  Receive endpoint that sits on one HNoC output port (o_pe_dataN/o_pe_data_validN/i_pe_data_readyN).
//  Accepts 32-bit packets under valid/ready, checks destination, source and per-source sequence,
//  counts packets, asserts done at a target count, and optionally gathers latency statistics.
//  Replaces ad-hoc receive counting in benches; one instance per PE port.
// PARAMETERS
//  ADDRESS        0    this port's PE address; compared with the packet dst field
//  NUM_PE         4    number of legal sources (1..16); sizes the sequence table
//  EXPECTED_PKTS  400  accepted-packet count that asserts o_done
//  STALL_RATE     0    backpressure level 0..15; 0 = ready every cycle after reset
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  i_data         in   32  packet from NoC
//  i_data_valid   in   1   packet valid
//  o_data_ready   out  1   sink ready (registered)
//  i_cycle        in   16  free-running global cycle count (injection timestamp base)
//  o_rx_count     out  32  packets accepted since reset
//  o_done         out  1   sticky; set when o_rx_count reaches EXPECTED_PKTS
//  o_err_dest     out  1   sticky; dst field != ADDRESS
//  o_err_src      out  1   sticky; src field >= NUM_PE
//  o_err_seq      out  1   sticky; sequence mismatch for a legal source
//  o_err_ovf      out  1   sticky; packet accepted while o_done already high
//  o_lat_min      out  16  minimum latency seen (cycles)
//  o_lat_max      out  16  maximum latency seen (cycles)
//  o_lat_sum      out  32  sum of latencies (saturating)
// BEHAVIOUR
//  Packet fields: [31:28] src, [27:24] dst, [23:16] seq, [15:0] injection timestamp.
//  Reset: o_data_ready=0, o_rx_count=0, o_done=0, all err=0, o_lat_min=16'hFFFF, o_lat_max=0,
//   o_lat_sum=0, sequence table all 0, throttle LFSR=16'hACE1. rst mid-operation clears everything
//   in the same edge; an in-flight stage-1 packet is discarded, not counted.
//  Handshake: transfer when i_data_valid & o_data_ready at posedge clk. i_data ignored otherwise.
//   Upstream may hold valid with ready low; no packet may be lost or counted twice.
//  Ready: cycle after reset deasserts, o_data_ready <= (STALL_RATE==0) | (lfsr[3:0] >= STALL_RATE).
//   LFSR (x^16+x^14+x^13+x^11) advances every cycle out of reset.
//  Pipeline: stage 1 registers accepted packet + latency = (i_cycle - ts) mod 2^16 (acceptance cycle);
//   stage 2 (next edge) updates counters, errors, table, stats. Outputs lag transfer by 2 cycles.
//   Back-to-back transfers every cycle fully supported.
//  Sequence: legal src -> expected = table[src]; mismatch sets o_err_seq; table[src] <= seq+1 (mod 256,
//   resync on mismatch; 255 -> 0 wrap is legal). Illegal src: o_err_src, table untouched.
//  Count: o_rx_count increments for every accepted packet including erroneous ones; wraps 2^32.
//   o_done set in the cycle o_rx_count becomes EXPECTED_PKTS; never cleared except by rst.
//   Accept with o_done already 1 -> o_err_ovf (counting continues).
// CONFIGURATION
//  NOC_SINK_LATENCY_EN defined: o_lat_min/max/sum updated in stage 2 for every accepted packet;
//   o_lat_sum saturates at 32'hFFFF_FFFF. Not defined: latency logic absent, o_lat_min=16'hFFFF,
//   o_lat_max=0, o_lat_sum=0 constant; timestamp field still carried but unused.
// STRUCTURE
//  Package noc_pkg: PKT_W=32, field msb/lsb localparams (SRC,DST,SEQ,TS), addr_t (4b), seq_t (8b),
//   ts_t (16b), LFSR seed/taps constant. Shared with packet generator.
//  Sub-module noc_lfsr_throttle: LFSR + STALL_RATE compare, outputs registered ready.
// TESTING
//  STALL_RATE=0, 4 sources send seq 0..99 to ADDRESS, valid every cycle -> o_rx_count=400, o_done
//   high exactly 2 cycles after 400th transfer, all err=0.
//  Packet dst=ADDRESS+1 -> o_err_dest=1 two cycles later, o_rx_count still increments.
//  src=1 sends seq 0,1,3 -> o_err_seq=1 on third; next seq 4 accepted without new error (resync).
//  NUM_PE=4, src=7 -> o_err_src=1, table unchanged (src 0..3 continue clean).
//  STALL_RATE=8, valid held continuously with changing data only on transfer -> every packet counted
//   once, o_data_ready low in some cycles, no err.
//  LATENCY_EN: ts=16'hFFF0, accepted at i_cycle=16'h0010 -> latency 32; min=max=32, sum=32.
//  401st packet -> o_err_ovf=1, o_rx_count=401; rst pulse mid-burst -> all outputs reset values next cycle.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: field positions, field types,
// stage-1 bundle and throttle LFSR constants (used by sink and generator).
package noc_pkg;

  localparam int PKT_W   = 32;
  localparam int SRC_MSB = 31;
  localparam int SRC_LSB = 28;
  localparam int DST_MSB = 27;
  localparam int DST_LSB = 24;
  localparam int SEQ_MSB = 23;
  localparam int SEQ_LSB = 16;
  localparam int TS_MSB  = 15;
  localparam int TS_LSB  = 0;

  typedef logic [3:0]  addr_t;
  typedef logic [7:0]  seq_t;
  typedef logic [15:0] ts_t;

  // x^16+x^14+x^13+x^11, shift-right Fibonacci form:
  // feedback = xor of bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef struct packed {
    addr_t src;
    addr_t dst;
    seq_t  seq;
    ts_t   lat;
  } s1_t;

endpackage

// File: rtl/noc_lfsr_throttle.sv
// Backpressure generator: 16-bit LFSR compared with STALL_RATE.
// Ports: clk, rst (sync, active-high), ready (registered).
module noc_lfsr_throttle
  import noc_pkg::*;
#(
  parameter int unsigned STALL_RATE = 0
) (
  input  logic clk,
  input  logic rst,
  output logic ready
);

  logic [15:0] lfsr;
  logic        fb;
  logic        go;

  assign fb = ^(lfsr & LFSR_TAPS);
  assign go = (STALL_RATE == 0) ||
              (lfsr[3:0] >= 4'(STALL_RATE));

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr  <= LFSR_SEED;
      ready <= 1'b0;
    end else begin
      lfsr  <= {fb, lfsr[15:1]};
      ready <= go;
    end
  end

endmodule

// File: rtl/noc_pkt_sink.sv
// NoC receive endpoint: valid/ready accept, dst/src/seq checks,
// packet count + done, optional latency stats (NOC_SINK_LATENCY_EN).
// Ports: clk, rst (sync, active-high); i_data, i_data_valid,
// o_data_ready; i_cycle (timestamp base); o_rx_count, o_done;
// o_err_dest/src/seq/ovf (sticky); o_lat_min/max/sum.
module noc_pkt_sink
  import noc_pkg::*;
#(
  parameter int unsigned ADDRESS       = 0,
  parameter int unsigned NUM_PE        = 4,
  parameter int unsigned EXPECTED_PKTS = 400,
  parameter int unsigned STALL_RATE    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] i_data,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  input  logic [15:0]      i_cycle,
  output logic [31:0]      o_rx_count,
  output logic             o_done,
  output logic             o_err_dest,
  output logic             o_err_src,
  output logic             o_err_seq,
  output logic             o_err_ovf,
  output logic [15:0]      o_lat_min,
  output logic [15:0]      o_lat_max,
  output logic [31:0]      o_lat_sum
);

  localparam logic [4:0] NPE = 5'(NUM_PE);

  logic        xfer;
  logic        s1_vld;
  s1_t         s1;
  seq_t        seq_tbl [NUM_PE];
  seq_t        exp_seq;
  logic        src_ok;
  logic [31:0] rx_next;

  noc_lfsr_throttle #(
    .STALL_RATE(STALL_RATE)
  ) u_thr (
    .clk  (clk),
    .rst  (rst),
    .ready(o_data_ready)
  );

  assign xfer = i_data_valid & o_data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= xfer;
      if (xfer) begin
        s1.src <= i_data[SRC_MSB:SRC_LSB];
        s1.dst <= i_data[DST_MSB:DST_LSB];
        s1.seq <= i_data[SEQ_MSB:SEQ_LSB];
        s1.lat <= i_cycle - i_data[TS_MSB:TS_LSB];
      end
    end
  end

  assign src_ok  = {1'b0, s1.src} < NPE;
  assign rx_next = o_rx_count + 32'd1;

  always_comb begin
    exp_seq = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (s1.src == addr_t'(i)) exp_seq = seq_tbl[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rx_count <= '0;
      o_done     <= 1'b0;
      o_err_dest <= 1'b0;
      o_err_src  <= 1'b0;
      o_err_seq  <= 1'b0;
      o_err_ovf  <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) seq_tbl[i] <= '0;
    end else if (s1_vld) begin
      o_rx_count <= rx_next;
      if (rx_next == 32'(EXPECTED_PKTS)) o_done <= 1'b1;
      if (o_done) o_err_ovf <= 1'b1;
      if (s1.dst != addr_t'(ADDRESS)) o_err_dest <= 1'b1;
      if (!src_ok) begin
        o_err_src <= 1'b1;
      end else begin
        if (s1.seq != exp_seq) o_err_seq <= 1'b1;
        // Resync: next expected follows the seq actually seen.
        for (int i = 0; i < NUM_PE; i++) begin
          if (s1.src == addr_t'(i)) seq_tbl[i] <= s1.seq + 8'd1;
        end
      end
    end
  end

`ifdef NOC_SINK_LATENCY_EN
  logic [32:0] sum_ext;

  assign sum_ext = {1'b0, o_lat_sum} + {17'b0, s1.lat};

  always_ff @(posedge clk) begin
    if (rst) begin
      o_lat_min <= 16'hFFFF;
      o_lat_max <= '0;
      o_lat_sum <= '0;
    end else if (s1_vld) begin
      if (s1.lat < o_lat_min) o_lat_min <= s1.lat;
      if (s1.lat > o_lat_max) o_lat_max <= s1.lat;
      o_lat_sum <= sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
    end
  end
`else
  logic unused_lat;

  assign unused_lat = ^s1.lat;
  assign o_lat_min  = 16'hFFFF;
  assign o_lat_max  = '0;
  assign o_lat_sum  = '0;
`endif

endmodule
